// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//   Bring-up / self-test monitor for locally generated divided clocks.
//   Samples clk_div as data in the clk_in domain and measures its high time,
//   low time and period in clk_in cycles. Reports lock once consecutive
//   measurements agree, and raises a sticky overflow on out-of-range or
//   stuck inputs.
//
//   Build option: define DIV_DET_SYNC_EN to put a 2-flop synchronizer in
//   front of the edge register when clk_div comes from an unrelated clock
//   domain (adds one cycle of latency, counts are unchanged).
//
// Ports
//   clk_in     : sampling clock
//   rst_n      : asynchronous active-low reset
//   clk_div    : divided clock under test (data only)
//   enable     : 1 = run, 0 = return to IDLE
//   clear      : one-cycle pulse clearing overflow
//   period     : last measured period
//   high_time  : last measured high time
//   low_time   : last measured low time
//   meas_valid : one-cycle pulse when new measurement values are written
//   locked     : LOCK_COUNT consecutive identical measurements seen
//   overflow   : sticky error, period reached MAX_DIV+1

module clk_div_monitor #(
   parameter int unsigned MAX_DIV    = 255,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned CNT_W      = $clog2(MAX_DIV + 1)
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             clk_div,
   input  logic             enable,
   input  logic             clear,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] low_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             overflow
);

   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned STK_W = $clog2(LOCK_COUNT + 1);

   localparam logic [SUM_W-1:0] SUM_LIMIT = SUM_W'(MAX_DIV + 1);
   localparam logic [STK_W-1:0] STK_LOCK  = STK_W'(LOCK_COUNT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      MEASURE   = 2'd2
   } state_t;

   // Input stage: s is the sampled clk_div, s_d the edge register.
   logic s;
   logic s_d;

`ifdef DIV_DET_SYNC_EN
   logic sync_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 1'b0;
         s      <= 1'b0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= clk_div;
         s      <= sync_q;
         s_d    <= s;
      end
   end
`else
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s   <= 1'b0;
         s_d <= 1'b0;
      end else begin
         s   <= clk_div;
         s_d <= s;
      end
   end
`endif

   logic rise_c;
   assign rise_c = s & ~s_d;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W-1:0] hi_cnt_nxt;
   logic [CNT_W-1:0] lo_cnt;
   logic [CNT_W-1:0] lo_cnt_nxt;
   logic [STK_W-1:0] streak;
   logic [STK_W-1:0] streak_nxt;
   logic [CNT_W-1:0] period_nxt;
   logic [CNT_W-1:0] high_time_nxt;
   logic [CNT_W-1:0] low_time_nxt;
   logic             meas_valid_nxt;
   logic             locked_nxt;
   logic             overflow_nxt;

   // One bit wider than the counters so the limit compare cannot wrap.
   logic [SUM_W-1:0] sum_c;
   assign sum_c = SUM_W'(hi_cnt) + SUM_W'(lo_cnt);

   // State and output registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hi_cnt     <= '0;
         lo_cnt     <= '0;
         streak     <= '0;
         period     <= '0;
         high_time  <= '0;
         low_time   <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         hi_cnt     <= hi_cnt_nxt;
         lo_cnt     <= lo_cnt_nxt;
         streak     <= streak_nxt;
         period     <= period_nxt;
         high_time  <= high_time_nxt;
         low_time   <= low_time_nxt;
         meas_valid <= meas_valid_nxt;
         locked     <= locked_nxt;
         overflow   <= overflow_nxt;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_nxt      = state;
      hi_cnt_nxt     = hi_cnt;
      lo_cnt_nxt     = lo_cnt;
      streak_nxt     = streak;
      period_nxt     = period;
      high_time_nxt  = high_time;
      low_time_nxt   = low_time;
      meas_valid_nxt = 1'b0;
      locked_nxt     = locked;
      // An overflow set below in the same cycle overrides the clear.
      overflow_nxt   = overflow & ~clear;

      if (!enable) begin
         state_nxt  = IDLE;
         hi_cnt_nxt = '0;
         lo_cnt_nxt = '0;
         streak_nxt = '0;
         locked_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt  = WAIT_RISE;
               hi_cnt_nxt = '0;
               lo_cnt_nxt = '0;
               streak_nxt = '0;
               locked_nxt = 1'b0;
            end

            // Discard the partial period in progress; the rise cycle is
            // already the first high cycle of the next period.
            WAIT_RISE: begin
               if (rise_c) begin
                  state_nxt  = MEASURE;
                  hi_cnt_nxt = CNT_W'(1);
                  lo_cnt_nxt = '0;
               end
            end

            MEASURE: begin
               if (rise_c) begin
                  period_nxt     = CNT_W'(sum_c);
                  high_time_nxt  = hi_cnt;
                  low_time_nxt   = lo_cnt;
                  meas_valid_nxt = 1'b1;
                  // Streak 0 marks the first measurement after WAIT_RISE.
                  if ((streak == '0) || (CNT_W'(sum_c) != period) ||
                      (hi_cnt != high_time)) begin
                     streak_nxt = STK_W'(1);
                  end else if (streak != STK_LOCK) begin
                     streak_nxt = streak + STK_W'(1);
                  end
                  locked_nxt = (streak_nxt == STK_LOCK);
                  hi_cnt_nxt = CNT_W'(1);
                  lo_cnt_nxt = '0;
               end else if ((sum_c + SUM_W'(1)) == SUM_LIMIT) begin
                  // Period too long or clk_div stuck: abandon and resync.
                  overflow_nxt = 1'b1;
                  locked_nxt   = 1'b0;
                  streak_nxt   = '0;
                  hi_cnt_nxt   = '0;
                  lo_cnt_nxt   = '0;
                  state_nxt    = WAIT_RISE;
               end else if (s) begin
                  hi_cnt_nxt = hi_cnt + CNT_W'(1);
               end else begin
                  lo_cnt_nxt = lo_cnt + CNT_W'(1);
               end
            end

            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor
//   Drives clk_div as a sequence of (high, low) segments and predicts the
//   monitor's behaviour segment by segment: every fully observed segment is
//   one measurement, a segment longer than MAX_DIV is an overflow, and the
//   lock streak is tracked over the measurement list. A monitor process
//   matches each meas_valid pulse against the predicted queue.

module tb_clk_div_monitor;

   localparam int MAX_DIV    = 15;
   localparam int LOCK_COUNT = 4;
   localparam int CNT_W      = $clog2(MAX_DIV + 1);
`ifdef DIV_DET_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic             clk_in = 1'b0;
   logic             rst_n  = 1'b1;
   logic             clk_div;
   logic             enable;
   logic             clear;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic [CNT_W-1:0] low_time;
   logic             meas_valid;
   logic             locked;
   logic             overflow;

   clk_div_monitor #(
      .MAX_DIV    (MAX_DIV),
      .LOCK_COUNT (LOCK_COUNT)
   ) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .clk_div    (clk_div),
      .enable     (enable),
      .clear      (clear),
      .period     (period),
      .high_time  (high_time),
      .low_time   (low_time),
      .meas_valid (meas_valid),
      .locked     (locked),
      .overflow   (overflow)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model state
   typedef struct {
      int p;
      int h;
      int l;
      bit lk;
      int due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   streak_m;
   int   prev_p, prev_h;
   int   last_p, last_h, last_l;
   bit   ovf_m;
   bit   armed;
   bit   pend;
   int   cur_h, cur_l;

   task automatic model_reset();
      streak_m = 0;
      prev_p   = 0;
      prev_h   = 0;
      last_p   = 0;
      last_h   = 0;
      last_l   = 0;
      ovf_m    = 1'b0;
      armed    = 1'b0;
      pend     = 1'b0;
   endtask

   task automatic push_meas(input int h, input int l);
      int p;
      p = h + l;
      if (streak_m == 0 || p != prev_p || h != prev_h) streak_m = 1;
      else if (streak_m < LOCK_COUNT) streak_m++;
      prev_p = p;
      prev_h = h;
      last_p = p;
      last_h = h;
      last_l = l;
      exp_q.push_back('{p: p, h: h, l: l, lk: (streak_m == LOCK_COUNT), due: cyc + LAT});
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_period"},     32'(period),     32'd0);
      chk({tag, "_high_time"},  32'(high_time),  32'd0);
      chk({tag, "_low_time"},   32'(low_time),   32'd0);
      chk({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
      chk({tag, "_locked"},     32'(locked),     32'd0);
      chk({tag, "_overflow"},   32'(overflow),   32'd0);
   endtask

   // One segment: rise, h cycles high, l cycles low. Optional events are
   // placed at cycle offsets from the rise (negative = unused).
   task automatic seg(input int h, input int l, input int drop_at = -1,
                      input int drop_len = 0, input int rst_at = -1,
                      input int clr_at = -1);
      bit seg_ovf;
      seg_ovf = 1'b0;
      for (int i = 0; i < h + l; i++) begin
         @(negedge clk_in);
         if (i == 0) begin
            if (pend) push_meas(cur_h, cur_l);
            cur_h = h;
            cur_l = l;
            if (armed && (h + l > MAX_DIV)) begin
               seg_ovf  = 1'b1;
               ovf_m    = 1'b1;
               streak_m = 0;
               pend     = 1'b0;
            end else begin
               pend = armed;
            end
            clk_div = 1'b1;
         end
         if (i == h) clk_div = 1'b0;
         if (drop_len > 0 && i == drop_at) begin
            enable   = 1'b0;
            armed    = 1'b0;
            pend     = 1'b0;
            streak_m = 0;
         end
         if (drop_len > 0 && i == drop_at + drop_len) begin
            enable = 1'b1;
            armed  = 1'b1;
         end
         if (rst_at >= 0 && i == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_zero("rst_mid");
            model_reset();
         end
         if (rst_at >= 0 && i == rst_at + 2) begin
            rst_n = 1'b1;
            armed = 1'b1;
         end
         if (clr_at >= 0 && i == clr_at) begin
            clear = 1'b1;
            if (!seg_ovf) ovf_m = 1'b0;
         end
         if (clr_at >= 0 && i == clr_at + 1) clear = 1'b0;
      end
   endtask

   // Pulse matcher: each meas_valid must match the oldest prediction,
   // arrive exactly on its due cycle, and no prediction may go stale.
   always @(posedge clk_in) begin
      #1;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         chk("missed_pulse_due", 32'(cyc), 32'(exp_q[0].due));
         void'(exp_q.pop_front());
      end
      if (meas_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'(meas_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("period",    32'(period),    32'(mon_e.p));
            chk("high_time", 32'(high_time), 32'(mon_e.h));
            chk("low_time",  32'(low_time),  32'(mon_e.l));
            chk("locked",    32'(locked),    32'(mon_e.lk));
            chk("latency",   32'(cyc),       32'(mon_e.due));
         end
      end
   end

   initial begin
      int h, l, n;
      clk_div = 1'b0;
      enable  = 1'b0;
      clear   = 1'b0;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk_in);
      enable = 1'b1;
      armed  = 1'b1;

      // Divide-by-3, high 2 low 1: lock on the 4th pulse
      repeat (5) seg(2, 1);

      // Divide-by-8 50% then divide-by-5 (3/2): lock drops and recovers
      repeat (6) seg(4, 4);
      repeat (5) seg(3, 2);

      // Random segment groups within range
      repeat (8) begin
         h = int'($urandom_range(7, 1));
         l = int'($urandom_range(7, 1));
         n = int'($urandom_range(6, 1));
         repeat (n) seg(h, l);
      end

      // Stuck-high overflow, then relock with overflow sticky
      chk("ovf_before", 32'(overflow), 32'(ovf_m));
      seg(20, 2);
      chk("ovf_set",    32'(overflow), 32'(ovf_m));
      chk("ovf_locked", 32'(locked),   32'(streak_m == LOCK_COUNT));
      repeat (6) seg(3, 3);
      chk("ovf_sticky", 32'(overflow), 32'(ovf_m));
      chk("relock",     32'(locked),   32'(streak_m == LOCK_COUNT));
      seg(3, 3, -1, 0, -1, 1);
      chk("ovf_clear",  32'(overflow), 32'(ovf_m));

      // Clear coinciding with the overflow event: set wins
      repeat (2) seg(3, 3);
      seg(20, 2, -1, 0, -1, LAT + MAX_DIV - 1);
      chk("ovf_clear_same_cycle", 32'(overflow), 32'(ovf_m));
      seg(3, 3, -1, 0, -1, 1);
      chk("ovf_clear_after", 32'(overflow), 32'(ovf_m));

      // Enable dropped mid-period for 3 cycles
      repeat (5) seg(3, 3);
      seg(4, 6, 5, 3);
      chk("drop_period",    32'(period),    32'(last_p));
      chk("drop_high_time", 32'(high_time), 32'(last_h));
      chk("drop_low_time",  32'(low_time),  32'(last_l));
      chk("drop_locked",    32'(locked),    32'd0);
      repeat (6) seg(3, 3);
      chk("drop_relock", 32'(locked), 32'(streak_m == LOCK_COUNT));

      // Reset asserted while measuring
      seg(3, 6, -1, 0, 4);
      repeat (6) seg(2, 3);
      chk("rst_relock", 32'(locked), 32'(streak_m == LOCK_COUNT));

      // Final rise closes the last segment; nothing may remain outstanding
      seg(1, 3);
      repeat (LAT + 3) @(negedge clk_in);
      chk("pending_at_end", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Receive-side checker for locally generated divided clocks. It samples a divided clock `clk_div` in the `clk_in` domain and measures its high time, low time and period in `clk_in` cycles. It asserts `locked` once the waveform is stable, and flags out-of-range or stuck inputs. It sits next to the clock dividers as a bring-up and self-test monitor; its outputs go to status registers.

## Interface
- `MAX_DIV`, default 255: largest measurable period in `clk_in` cycles. Must be ≥ 3.
- `LOCK_COUNT`, default 4: number of consecutive identical measurements required for lock. Must be ≥ 2.
- `CNT_W`, default `$clog2(MAX_DIV+1)`: width of the count outputs. Derived; do not override.
- `clk_in`, input, 1: sampling clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `clk_div`, input, 1: divided clock under test. Treated as data, never used as a clock.
- `enable`, input, 1: 1 = run, 0 = return to IDLE.
- `clear`, input, 1: one-cycle pulse that clears `overflow`.
- `period`, output, `CNT_W`: last measured period.
- `high_time`, output, `CNT_W`: last measured high time.
- `low_time`, output, `CNT_W`: last measured low time.
- `meas_valid`, output, 1: one-cycle pulse when new measurement values are written.
- `locked`, output, 1: stable-waveform indication.
- `overflow`, output, 1: sticky error flag.

## Operation
- Sampled signal `s` is `clk_div` after the input stage (see Configuration). `s_d` is `s` delayed by one cycle.
- Rising edge: `s & ~s_d`.
- FSM states:
  - IDLE: entered from reset, or whenever `enable`=0 (from any state, immediately). Counters and streak are zeroed; `locked`=0.
  - WAIT_RISE: entered from IDLE when `enable`=1. It discards the first partial period. On a rising edge: `hi_cnt`←1, `lo_cnt`←0, go to MEASURE, no pulse.
  - MEASURE:
    - Each cycle, `hi_cnt`++ if `s`=1, else `lo_cnt`++.
    - On a rising edge: `high_time`←`hi_cnt`, `low_time`←`lo_cnt`, `period`←`hi_cnt`+`lo_cnt`, pulse `meas_valid`, then `hi_cnt`←1, `lo_cnt`←0.
- Overflow:
  - Condition: in MEASURE, `hi_cnt`+`lo_cnt` would reach `MAX_DIV`+1. This covers a stuck-high or stuck-low `clk_div`.
  - Action: set `overflow`, clear `locked` and streak, go to WAIT_RISE. No `meas_valid` is issued.
  - Sum arithmetic is `CNT_W`+1 bits wide.
- Lock:
  - Each `meas_valid` compares the new `period`/`high_time` with the previous values. Equal increments the streak (saturating at `LOCK_COUNT`); different sets the streak to 1.
  - The first measurement after WAIT_RISE sets streak = 1.
  - `locked` = (streak == `LOCK_COUNT`). It is registered and updates in the same cycle as `meas_valid`.
- `clear` and an overflow event in the same cycle: set wins.
- Reset values: `period`, `high_time`, `low_time` = 0; `meas_valid`, `locked`, `overflow` = 0; state IDLE.
- Measurement outputs hold their values through IDLE and WAIT_RISE.

## Timing
- All outputs are registered on `clk_in`.
- `meas_valid` latency: it is high in the cycle following the 2nd `clk_in` edge after the first edge that samples `clk_div`=1. With `DIV_DET_SYNC_EN`, this becomes the 3rd edge.
- Mid-period `enable` drop: the partial counts are discarded and no pulse is issued. Re-enable restarts at WAIT_RISE.
- Asynchronous reset mid-measurement: all state and outputs return to reset values at once.

## Configuration
- `DIV_DET_SYNC_EN`
  - Defined: `clk_div` passes through a 2-flop synchronizer, then the edge register. Use this for a `clk_div` from an unrelated clock domain. Adds 1 cycle of latency.
  - Undefined: a single input register only. For dividers clocked by `clk_in`.
- Measured counts are identical in both builds.

## Test plan
- Divide-by-3 pattern (high 2, low 1), `enable`=1 → first `meas_valid` after one full period reports `period`=3, `high_time`=2, `low_time`=1. `locked`=1 on the 4th pulse.
- Divide-by-8 at 50% duty, then switch to divide-by-5 (high 3, low 2) → `locked` drops on the first 5-cycle measurement (`period`=5, `high_time`=3), and re-locks 3 pulses later.
- `MAX_DIV`=15, `clk_div` held high for 20 cycles while in MEASURE → `overflow`=1 and `locked`=0 at sum 16, no `meas_valid`. Toggling resumes → new lock after 4 periods; `overflow` stays 1 until `clear`.
- `clear` pulsed in the same cycle as an overflow event → `overflow` remains 1. `clear` alone next → 0.
- `enable` deasserted mid-period, reasserted 3 cycles later → no `meas_valid` for the first partial period, outputs held meanwhile, `locked` cleared.
- `rst_n` asserted during MEASURE → all outputs 0 immediately. After release, the first valid measurement arrives only after one discarded partial period.
